// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end. Issues icache requests from the
// fetch PC, queues returned instructions in order and presents the head entry
// to decode. Redirects flush the queue and discard stale in-flight responses.
//
// Optional feature macro: FETCH_EXC_EN
//   defined   - access faults (IC_RSP_ERR) and misaligned fetch PCs produce an
//               exception entry and stop fetch until the next redirect.
//   undefined - DE_IAF/DE_IAM read 0, IC_RSP_ERR is ignored, and the low two
//               bits of REDIR_PC/RESET_PC are forced to zero.
//
// Ports:
//   CLK, RESET            clock, async active-high reset
//   IC_REQ_V/PC/RDY       icache request handshake
//   IC_RSP_V/IR/ERR       icache response (in request order)
//   REDIR_V/PC            redirect (highest priority)
//   DE_V/RDY/IR/PC/NPC    head entry to decode
//   DE_IAF/DE_IAM         head entry exception flags
//   FQ_CNT                queue occupancy
module fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    output logic                     IC_REQ_V,
    output logic [XLEN-1:0]          IC_REQ_PC,
    input  logic                     IC_REQ_RDY,
    input  logic                     IC_RSP_V,
    input  logic [31:0]              IC_RSP_IR,
    input  logic                     IC_RSP_ERR,
    input  logic                     REDIR_V,
    input  logic [XLEN-1:0]          REDIR_PC,
    input  logic                     DE_RDY,
    output logic                     DE_V,
    output logic [31:0]              DE_IR,
    output logic [XLEN-1:0]          DE_PC,
    output logic [XLEN-1:0]          DE_NPC,
    output logic                     DE_IAF,
    output logic                     DE_IAM,
    output logic [$clog2(DEPTH):0]   FQ_CNT
);
    // state | meaning
    // RUN   | issue requests, enqueue responses
    // FLUSH | discard responses still in flight from before a redirect
    // HALT  | exception entry queued; no new requests until a redirect
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HALT = 2'd2} state_t;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc;
    logic [OW-1:0]     outstanding, drop, in_flight_left;
    logic [TW-1:0]     tag_wr, tag_rd;
    logic [XLEN-1:0]   tag_mem [MAX_OUT];
    logic [QW-1:0]     q_head, q_tail;
    logic [CW-1:0]     fq_cnt;
    logic [31:0]       q_ir  [DEPTH];
    logic [XLEN-1:0]   q_pc  [DEPTH];
    logic              q_iaf [DEPTH];
    logic              q_iam [DEPTH];

    logic              req_fire, rsp_take, rsp_drop, rsp_any, mis_fire, q_push, de_pop, q_full;
    logic              rsp_err;
    logic [XLEN-1:0]   redir_pc_eff;
    logic [31:0]       push_ir;
    logic [XLEN-1:0]   push_pc;
    logic              push_iaf, push_iam;

`ifdef FETCH_EXC_EN
    localparam logic [XLEN-1:0] RESET_PC_EFF = RESET_PC;
    assign rsp_err      = IC_RSP_ERR;
    assign redir_pc_eff = REDIR_PC;
    assign mis_fire     = (state == RUN) && !REDIR_V && (pc[1:0] != 2'b00)
                          && (outstanding == '0) && !q_full;
`else
    localparam logic [XLEN-1:0] RESET_PC_EFF = {RESET_PC[XLEN-1:2], 2'b00};
    logic unused_cfg;
    assign unused_cfg   = ^{IC_RSP_ERR, REDIR_PC[1:0]};
    assign rsp_err      = 1'b0;
    assign redir_pc_eff = {REDIR_PC[XLEN-1:2], 2'b00};
    assign mis_fire     = 1'b0;
`endif

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (32'(p) == 32'(MAX_OUT - 1)) ? '0 : p + TW'(1);
    endfunction

    // Credit check counts queued entries plus in-flight requests so a
    // returning response always has a free slot.
    assign IC_REQ_V  = !RESET && (state == RUN) && !REDIR_V && (pc[1:0] == 2'b00)
                       && (32'(outstanding) < 32'(MAX_OUT))
                       && (32'(outstanding) + 32'(fq_cnt) < 32'(DEPTH));
    assign IC_REQ_PC = pc;
    assign req_fire  = IC_REQ_V && IC_REQ_RDY;

    assign q_full    = (fq_cnt == CW'(DEPTH));
    assign rsp_take  = IC_RSP_V && !REDIR_V && (state != FLUSH) && (outstanding != '0);
    assign rsp_drop  = IC_RSP_V && !REDIR_V && (state == FLUSH) && (drop != '0);
    assign q_push    = rsp_take || mis_fire;

    // Only one of outstanding/drop is ever non-zero, so their sum is the
    // number of responses still owed by the icache. A redirect during FLUSH
    // must keep dropping the older stale responses as well.
    assign rsp_any        = IC_RSP_V && ((outstanding != '0) || (drop != '0));
    assign in_flight_left = outstanding + drop - OW'(rsp_any);

    assign DE_V    = (fq_cnt != '0) && !REDIR_V;
    assign de_pop  = DE_V && DE_RDY;
    assign DE_IR   = (fq_cnt != '0) ? q_ir[q_head]  : '0;
    assign DE_PC   = (fq_cnt != '0) ? q_pc[q_head]  : '0;
    assign DE_IAF  = (fq_cnt != '0) && q_iaf[q_head];
    assign DE_IAM  = (fq_cnt != '0) && q_iam[q_head];
    assign DE_NPC  = DE_PC + XLEN'(4);
    assign FQ_CNT  = fq_cnt;

    always_comb begin
        push_ir  = IC_RSP_IR;
        push_pc  = tag_mem[tag_rd];
        push_iaf = rsp_err;
        push_iam = 1'b0;
        if (mis_fire) begin
            push_ir  = 32'h0000_0013;
            push_pc  = pc;
            push_iaf = 1'b0;
            push_iam = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (REDIR_V) begin
            state_nxt = (in_flight_left != '0) ? FLUSH : RUN;
        end else begin
            case (state)
                RUN:     if (mis_fire || (rsp_take && rsp_err)) state_nxt = HALT;
                FLUSH:   if ((drop == '0) || (rsp_drop && (drop == OW'(1)))) state_nxt = RUN;
                HALT:    state_nxt = HALT;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= RUN;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc          <= RESET_PC_EFF;
            outstanding <= '0;
            drop        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            fq_cnt      <= '0;
        end else if (REDIR_V) begin
            pc          <= redir_pc_eff;
            outstanding <= '0;
            drop        <= in_flight_left;
            tag_wr      <= '0;
            tag_rd      <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            fq_cnt      <= '0;
        end else begin
            if (req_fire) begin
                pc     <= pc + XLEN'(4);
                tag_wr <= tag_inc(tag_wr);
            end
            if (rsp_take) tag_rd <= tag_inc(tag_rd);
            if (rsp_drop) drop <= drop - OW'(1);
            if (q_push)   q_tail <= q_tail + QW'(1);
            if (de_pop)   q_head <= q_head + QW'(1);
            outstanding <= outstanding + OW'(req_fire) - OW'(rsp_take);
            fq_cnt      <= fq_cnt + CW'(q_push) - CW'(de_pop);
        end
    end

    // Storage arrays carry no reset; occupancy and pointers define validity.
    always_ff @(posedge CLK) begin
        if (req_fire) tag_mem[tag_wr] <= pc;
        if (q_push) begin
            q_ir[q_tail]  <= push_ir;
            q_pc[q_tail]  <= push_pc;
            q_iaf[q_tail] <= push_iaf;
            q_iam[q_tail] <= push_iam;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    logic        CLK, RESET;
    logic        IC_REQ_V, IC_REQ_RDY, IC_RSP_V, IC_RSP_ERR, REDIR_V, DE_RDY;
    logic        DE_V, DE_IAF, DE_IAM;
    logic [63:0] IC_REQ_PC, REDIR_PC, DE_PC, DE_NPC;
    logic [31:0] IC_RSP_IR, DE_IR;
    logic [2:0]  FQ_CNT;

    fetch_queue #(.XLEN(64), .DEPTH(4), .MAX_OUT(2), .RESET_PC(64'h1000)) dut (
        .CLK(CLK), .RESET(RESET),
        .IC_REQ_V(IC_REQ_V), .IC_REQ_PC(IC_REQ_PC), .IC_REQ_RDY(IC_REQ_RDY),
        .IC_RSP_V(IC_RSP_V), .IC_RSP_IR(IC_RSP_IR), .IC_RSP_ERR(IC_RSP_ERR),
        .REDIR_V(REDIR_V), .REDIR_PC(REDIR_PC), .DE_RDY(DE_RDY),
        .DE_V(DE_V), .DE_IR(DE_IR), .DE_PC(DE_PC), .DE_NPC(DE_NPC),
        .DE_IAF(DE_IAF), .DE_IAM(DE_IAM), .FQ_CNT(FQ_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ir;
        logic        iaf;
        logic        iam;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] pend[$];
    int          pop_cyc[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0;
    int          budget;
    logic        rsp_en;
    logic [63:0] err_pc;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] ir_of(input logic [63:0] p);
        return p[31:0] ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic iaf, input logic iam);
        exp_t e;
        e.pc  = pc;
        e.ir  = iam ? 32'h0000_0013 : ir_of(pc);
        e.iaf = iaf;
        e.iam = iam;
        sb.push_back(e);
    endtask

    // One cycle of the icache model: returns the oldest accepted request
    // (1-cycle latency when rsp_en) and grants while budget remains.
    task automatic tick();
        logic [63:0] p;
        if (rsp_en && pend.size() > 0) begin
            p          = pend.pop_front();
            IC_RSP_V   = 1'b1;
            IC_RSP_IR  = ir_of(p);
            IC_RSP_ERR = (p == err_pc);
        end else begin
            IC_RSP_V   = 1'b0;
            IC_RSP_IR  = '0;
            IC_RSP_ERR = 1'b0;
        end
        IC_REQ_RDY = (budget > 0);
        #1;
        if (IC_REQ_V && IC_REQ_RDY) begin
            pend.push_back(IC_REQ_PC);
            budget--;
        end
        @(negedge CLK);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || FQ_CNT != 0 || pend.size() != 0) && k < 40) begin
            tick();
            k++;
        end
        chk({name, "_left"}, 64'(sb.size()), 64'd0);
        chk({name, "_cnt"}, 64'(FQ_CNT), 64'd0);
    endtask

    task automatic redirect(input logic [63:0] target);
        REDIR_V  = 1'b1;
        REDIR_PC = target;
        tick();
        REDIR_V  = 1'b0;
    endtask

    // Monitor: every accepted head entry is compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #3;
            if (DE_V && DE_RDY) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pop: got pc %h want no entry", DE_PC);
                end else begin
                    e = sb.pop_front();
                    chk("de_pc",  DE_PC,         e.pc);
                    chk("de_ir",  64'(DE_IR),    64'(e.ir));
                    chk("de_npc", DE_NPC,        e.pc + 64'd4);
                    chk("de_iaf", 64'(DE_IAF),   64'(e.iaf));
                    chk("de_iam", 64'(DE_IAM),   64'(e.iam));
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int c0;
        CLK = 0; RESET = 1; IC_REQ_RDY = 0; IC_RSP_V = 0; IC_RSP_IR = '0; IC_RSP_ERR = 0;
        REDIR_V = 0; REDIR_PC = '0; DE_RDY = 0; budget = 0; rsp_en = 1; err_pc = '1;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_req_v",  64'(IC_REQ_V), 64'd0);
        chk("rst_de_v",   64'(DE_V),     64'd0);
        chk("rst_fq_cnt", 64'(FQ_CNT),   64'd0);
        chk("rst_pc",     IC_REQ_PC,     64'h1000);
        chk("rst_de_ir",  64'(DE_IR),    64'd0);
        @(negedge CLK);
        RESET = 0;

        // Fill partly, then reset mid-operation.
        budget = 3;
        repeat (4) tick();
        chk("mid_fq_cnt", 64'(FQ_CNT), 64'd3);
        chk("mid_pc",     IC_REQ_PC,   64'h100C);
        RESET = 1;
        #1;
        chk("mid_rst_cnt",   64'(FQ_CNT),   64'd0);
        chk("mid_rst_de_v",  64'(DE_V),     64'd0);
        chk("mid_rst_de_ir", 64'(DE_IR),    64'd0);
        chk("mid_rst_req_v", 64'(IC_REQ_V), 64'd0);
        chk("mid_rst_pc",    IC_REQ_PC,     64'h1000);
        pend.delete();
        budget = 0;
        @(negedge CLK);
        RESET = 0;

        // Streaming: one entry per cycle, 2-cycle first latency.
        DE_RDY = 1;
        pop_cyc.delete();
        push_exp(64'h1000, 0, 0); push_exp(64'h1004, 0, 0); push_exp(64'h1008, 0, 0);
        push_exp(64'h100C, 0, 0); push_exp(64'h1010, 0, 0); push_exp(64'h1014, 0, 0);
        c0 = cyc;
        budget = 6;
        drain("seq");
        chk("seq_pops", 64'(pop_cyc.size()), 64'd6);
        if (pop_cyc.size() == 6) begin
            chk("seq_latency", 64'(pop_cyc[0] - c0), 64'd2);
            chk("seq_steady",  64'(pop_cyc[5] - pop_cyc[0]), 64'd5);
        end

        // Backpressure: queue fills to 4 and issue stops.
        DE_RDY = 0;
        budget = 6;
        push_exp(64'h1018, 0, 0); push_exp(64'h101C, 0, 0); push_exp(64'h1020, 0, 0);
        push_exp(64'h1024, 0, 0); push_exp(64'h1028, 0, 0); push_exp(64'h102C, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("credit", 64'((pend.size() + int'(FQ_CNT)) <= 4), 64'd1);
        end
        chk("bp_fq_cnt", 64'(FQ_CNT),   64'd4);
        chk("bp_req_v",  64'(IC_REQ_V), 64'd0);
        DE_RDY = 1;
        drain("bp");

        // Redirect with a non-empty queue and 2 outstanding requests.
        DE_RDY = 0;
        budget = 2;
        repeat (4) tick();
        rsp_en = 0;
        budget = 2;
        repeat (2) tick();
        chk("pre_redir_cnt", 64'(FQ_CNT), 64'd2);
        DE_RDY = 1;
        REDIR_V = 1; REDIR_PC = 64'h2000;
        #1;
        chk("redir_de_v",  64'(DE_V),     64'd0);
        chk("redir_req_v", 64'(IC_REQ_V), 64'd0);
        tick();
        REDIR_V = 0;
        rsp_en = 1;
        budget = 3;
        #1;
        chk("flush_cnt",   64'(FQ_CNT),   64'd0);
        chk("flush_req_v", 64'(IC_REQ_V), 64'd0);
        push_exp(64'h2000, 0, 0); push_exp(64'h2004, 0, 0); push_exp(64'h2008, 0, 0);
        drain("redir");

        // PC wrap at the top of the address space.
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        budget = 2;
        push_exp(64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        push_exp(64'h0, 0, 0);
        drain("wrap");

`ifdef FETCH_EXC_EN
        // Misaligned redirect: single exception entry, no requests.
        redirect(64'h2002);
        budget = 2;
        push_exp(64'h2002, 0, 1);
        drain("iam");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("iam_req_v", 64'(IC_REQ_V), 64'd0);
        end
        chk("iam_budget", 64'(budget), 64'd2);

        // Access fault on 0x1008; the request already in flight still lands.
        err_pc = 64'h1008;
        redirect(64'h1000);
        budget = 6;
        push_exp(64'h1000, 0, 0); push_exp(64'h1004, 0, 0);
        push_exp(64'h1008, 1, 0); push_exp(64'h100C, 0, 0);
        drain("iaf");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("iaf_req_v", 64'(IC_REQ_V), 64'd0);
        end
        chk("iaf_budget", 64'(budget), 64'd2);
        err_pc = '1;
        budget = 0;
        redirect(64'h3000);
        budget = 1;
        push_exp(64'h3000, 0, 0);
        drain("halt_exit");
`else
        // Low PC bits are cleared and access faults are ignored.
        redirect(64'h2002);
        budget = 2;
        push_exp(64'h2000, 0, 0); push_exp(64'h2004, 0, 0);
        drain("noexc_align");
        err_pc = 64'h1008;
        redirect(64'h1000);
        budget = 4;
        push_exp(64'h1000, 0, 0); push_exp(64'h1004, 0, 0);
        push_exp(64'h1008, 0, 0); push_exp(64'h100C, 0, 0);
        drain("noexc_err");
        chk("noexc_budget", 64'(budget), 64'd0);
        err_pc = '1;
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
